screen_stream_controller: RTL and testbench
===========================================

# screen_stream_controller

Parametrised framebuffer-to-panel streamer that supersedes the fixed 128×128 controller. It owns a dual-port framebuffer that host logic writes pixel-by-pixel. It reads back a programmable rectangular window in raster order and hands pixels to the ST7735 serial interface over a valid/ready handshake. It supports continuous refresh and single-shot (start-triggered) frames, and reports frame boundaries.

## Interface
- `H_RES`, 128, horizontal pixels
- `V_RES`, 128, vertical pixels
- `PIXEL_W`, 16, bits per pixel (RGB565 default)
- `ADDR_W`, 7, coordinate width; must satisfy 2^ADDR_W ≥ max(H_RES, V_RES)

Ports:
- `clk_main` in 1: sole clock
- `rst` in 1: reset, asynchronous, active-high
- `enable` in 1: streaming permitted
- `lcd_ready` in 1: panel initialised (interface `is_init`)
- `mode` in 1: 0 = continuous, 1 = single-shot
- `start` in 1: single-shot frame request, 1-cycle pulse
- `win_x0`, `win_y0`, `win_x1`, `win_y1` in ADDR_W: inclusive window corners
- `pixel_wr_en` in 1, `pixel_addr_x` in ADDR_W, `pixel_addr_y` in ADDR_W, `pixel_wr_data` in PIXEL_W: framebuffer write port
- `pix_out_data` out PIXEL_W, `pix_out_valid` out 1, `pix_out_ready` in 1: stream to interface (`ready` = interface `buffer_free`)
- `busy` out 1: frame in progress
- `frame_start` out 1, `frame_done` out 1: 1-cycle pulses

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- **Frame start from IDLE.** A frame starts when `enable` && `lcd_ready` and one of the following holds: mode=0, or mode=1 and `start`=1.
  - On start: latch the window, clamp x1 to H_RES-1 and y1 to V_RES-1, set cursor to (x0, y0), pulse `frame_start`, go to ISSUE.
  - Degenerate window (x0>x1 or y0>y1 after clamping) → substitute the full screen.
- **ISSUE:** memory read of the cursor pixel, then go to WAIT.
- **WAIT:** register memory output into `pix_out_data`, then go to HOLD.
- **HOLD:** `pix_out_valid`=1 until `pix_out_ready`; data stays stable while valid.
- **On handshake:** cursor advances x+1. At x1, x returns to x0 and y increments.
  - After the pixel at (x1, y1), pulse `frame_done`.
  - mode=0: immediately restart (relatch window, `frame_start`).
  - mode=1: return to IDLE.
- **`enable` or `lcd_ready` low mid-frame:** a pending HOLD still completes its handshake. ISSUE is not entered while either is low, so the cursor is frozen. Streaming resumes when both are high.
- **Window/mode changes mid-frame** are ignored until the next frame start.
- `start` while busy, or while `enable` is low, is dropped (not queued).
- **Writes** are accepted every cycle out of reset, independent of `enable` and FSM state. Writes with x ≥ H_RES or y ≥ V_RES are discarded.
- **Same-address read/write in one cycle** returns old data (read-before-write).

## Timing
- Reset values: `pix_out_valid`=0, `pix_out_data`=0, `busy`=0, `frame_start`=0, `frame_done`=0, cursor=(0,0), state IDLE. Framebuffer contents undefined.
- Memory read latency: 1 cycle.
- Start qualified at cycle 0 (`frame_start` high in cycle 0's registered output, state ISSUE at cycle 1) → first `pix_out_valid` at cycle 3.
- Throughput with `ready` held high: 1 pixel per 3 cycles.
- `frame_done` is asserted in the cycle after the last handshake.
- `busy` is high from the `frame_start` cycle to the `frame_done` cycle inclusive. In mode 0 it stays high across frames.
- A write is visible to reads issued ≥1 cycle after the write cycle.
- Reset asserted mid-frame: outputs reach reset values asynchronously; no `frame_done` is emitted.

## Structure
- Package `screen_pkg`: state enum, mode constants (MODE_CONT, MODE_SINGLE), address-width helper function.
- Sub-module `screen_frame_memory`:
  - simple dual-port RAM, depth H_RES*V_RES, PIXEL_W wide;
  - linear address y*H_RES+x computed inside the sub-module;
  - registered read, read-before-write.

## Test plan
- **Full frame:** 4×4 config, mode=1, write pattern `{y,x}`, `start`, `ready`=1 → 16 pixels in raster order 0x00..0x33, one per 3 cycles, single `frame_done`.
- **Window:** 128×128 config, window (5,2)-(7,3) → exactly 6 pixels: (5,2),(6,2),(7,2),(5,3),(6,3),(7,3).
- **Backpressure:** drop `ready` for 10 cycles while valid=1 → data stable, no pixel lost or duplicated.
- **Continuous mode with mid-frame window change:** frame 2 uses the new window; `busy` stays 1; `frame_done` is followed by `frame_start` in the next cycle.
- **Write collision and out-of-range write:**
  - write 0xABCD to the pixel being read in the same cycle → old value output, 0xABCD on the next frame;
  - write to x=H_RES → no change.
- **Reset mid-frame:** reset after the 5th pixel → valid=0 immediately; a new frame restarts from (x0, y0).

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types and helpers for the screen streaming controller.
package screen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // Smallest bit count able to address 'depth' entries (at least 1).
    function automatic int addr_bits(input int depth);
        int n;
        n = 1;
        while ((1 << n) < depth) n++;
        return n;
    endfunction

endpackage

// File: rtl/screen_frame_memory.sv
// Framebuffer: simple dual-port RAM addressed by (x, y), registered read,
// read-before-write on a same-address collision.
module screen_frame_memory
    import screen_pkg::*;
#(
    parameter int H_RES   = 128,
    parameter int V_RES   = 128,
    parameter int PIXEL_W = 16,
    parameter int ADDR_W  = 7
) (
    input  logic               clk_main,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_x,
    input  logic [ADDR_W-1:0]  wr_y,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_x,
    input  logic [ADDR_W-1:0]  rd_y,
    output logic [PIXEL_W-1:0] rd_data
);

    localparam int DEPTH  = H_RES * V_RES;
    localparam int MEM_AW = addr_bits(DEPTH);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic [MEM_AW-1:0]  wr_addr;
    logic [MEM_AW-1:0]  rd_addr;
    logic               wr_in_range;

    // Out-of-range coordinates would alias onto other pixels, so drop them.
    assign wr_in_range = ({1'b0, wr_x} < (ADDR_W+1)'(H_RES)) &&
                         ({1'b0, wr_y} < (ADDR_W+1)'(V_RES));
    assign wr_addr = MEM_AW'(wr_y) * MEM_AW'(H_RES) + MEM_AW'(wr_x);
    assign rd_addr = MEM_AW'(rd_y) * MEM_AW'(H_RES) + MEM_AW'(rd_x);

    always_ff @(posedge clk_main) begin
        if (wr_en && wr_in_range) mem[wr_addr] <= wr_data;
        if (rd_en)                rd_data      <= mem[rd_addr];
    end

endmodule

// File: rtl/screen_stream_controller.sv
// Streams a programmable window of the framebuffer to the panel interface
// in raster order over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a frame trigger (continuous or start pulse)
// ISSUE | framebuffer read of the cursor pixel
// WAIT  | read data lands in the output register
// HOLD  | pixel offered (valid=1) until taken; valid=0 here means paused
module screen_stream_controller
    import screen_pkg::*;
#(
    parameter int H_RES   = 128,
    parameter int V_RES   = 128,
    parameter int PIXEL_W = 16,
    parameter int ADDR_W  = 7
) (
    input  logic               clk_main,
    input  logic               rst,
    input  logic               enable,
    input  logic               lcd_ready,
    input  logic               mode,
    input  logic               start,
    input  logic [ADDR_W-1:0]  win_x0,
    input  logic [ADDR_W-1:0]  win_y0,
    input  logic [ADDR_W-1:0]  win_x1,
    input  logic [ADDR_W-1:0]  win_y1,
    input  logic               pixel_wr_en,
    input  logic [ADDR_W-1:0]  pixel_addr_x,
    input  logic [ADDR_W-1:0]  pixel_addr_y,
    input  logic [PIXEL_W-1:0] pixel_wr_data,
    output logic [PIXEL_W-1:0] pix_out_data,
    output logic               pix_out_valid,
    input  logic               pix_out_ready,
    output logic               busy,
    output logic               frame_start,
    output logic               frame_done
);

    localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(V_RES - 1);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cur_x, cur_y, cur_x_nx, cur_y_nx;
    logic [ADDR_W-1:0]   wx0, wy0, wx1, wy1;
    logic [ADDR_W-1:0]   wx0_nx, wy0_nx, wx1_nx, wy1_nx;
    logic [ADDR_W-1:0]   cx1, cy1;
    logic [PIXEL_W-1:0]  data_nx, rd_data;
    logic                valid_nx, busy_nx, fstart_nx, fdone_nx;
    logic                go, start_ok, degenerate, handshake, last_px;

    assign go         = enable && lcd_ready;
    assign start_ok   = go && ((mode == MODE_CONT) || (start && !busy));
    assign cx1        = (win_x1 > X_MAX) ? X_MAX : win_x1;
    assign cy1        = (win_y1 > Y_MAX) ? Y_MAX : win_y1;
    assign degenerate = (win_x0 > cx1) || (win_y0 > cy1);
    assign handshake  = (state == ST_HOLD) && pix_out_valid && pix_out_ready;
    assign last_px    = (cur_x == wx1) && (cur_y == wy1);

    screen_frame_memory #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .PIXEL_W (PIXEL_W),
        .ADDR_W  (ADDR_W)
    ) u_mem (
        .clk_main (clk_main),
        .wr_en    (pixel_wr_en),
        .wr_x     (pixel_addr_x),
        .wr_y     (pixel_addr_y),
        .wr_data  (pixel_wr_data),
        .rd_en    (state == ST_ISSUE),
        .rd_x     (cur_x),
        .rd_y     (cur_y),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cur_x         <= '0;
            cur_y         <= '0;
            wx0           <= '0;
            wy0           <= '0;
            wx1           <= '0;
            wy1           <= '0;
            pix_out_data  <= '0;
            pix_out_valid <= 1'b0;
            busy          <= 1'b0;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            cur_x         <= cur_x_nx;
            cur_y         <= cur_y_nx;
            wx0           <= wx0_nx;
            wy0           <= wy0_nx;
            wx1           <= wx1_nx;
            wy1           <= wy1_nx;
            pix_out_data  <= data_nx;
            pix_out_valid <= valid_nx;
            busy          <= busy_nx;
            frame_start   <= fstart_nx;
            frame_done    <= fdone_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cur_x_nx  = cur_x;
        cur_y_nx  = cur_y;
        wx0_nx    = wx0;
        wy0_nx    = wy0;
        wx1_nx    = wx1;
        wy1_nx    = wy1;
        data_nx   = pix_out_data;
        valid_nx  = pix_out_valid;
        busy_nx   = busy;
        fstart_nx = 1'b0;
        fdone_nx  = 1'b0;

        case (state)
            ST_IDLE: begin
                // busy survives the frame_done cycle so continuous mode never drops it
                busy_nx = start_ok;
                if (start_ok) begin
                    if (degenerate) begin
                        wx0_nx = '0;
                        wy0_nx = '0;
                        wx1_nx = X_MAX;
                        wy1_nx = Y_MAX;
                    end else begin
                        wx0_nx = win_x0;
                        wy0_nx = win_y0;
                        wx1_nx = cx1;
                        wy1_nx = cy1;
                    end
                    cur_x_nx  = degenerate ? '0 : win_x0;
                    cur_y_nx  = degenerate ? '0 : win_y0;
                    fstart_nx = 1'b1;
                    state_nx  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT: begin
                data_nx  = rd_data;
                valid_nx = 1'b1;
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake) begin
                    valid_nx = 1'b0;
                    if (last_px) begin
                        fdone_nx = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        if (cur_x == wx1) begin
                            cur_x_nx = wx0;
                            cur_y_nx = cur_y + ADDR_W'(1);
                        end else begin
                            cur_x_nx = cur_x + ADDR_W'(1);
                        end
                        if (go) state_nx = ST_ISSUE;
                    end
                end else if (!pix_out_valid && go) begin
                    state_nx = ST_ISSUE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_screen_stream_controller.sv
// Scoreboard bench: a 4x4 instance for frame/timing/collision/reset cases and a
// 128x128 instance for the windowed read.
module tb_screen_stream_controller;

    logic clk_main = 1'b0;
    always #5 clk_main = ~clk_main;

    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // 4x4 instance
    logic        s_enable, s_lcd_ready, s_mode, s_start, s_wr_en, s_ready;
    logic [2:0]  s_wx0, s_wy0, s_wx1, s_wy1, s_px, s_py;
    logic [15:0] s_wr_data, s_data;
    logic        s_valid, s_busy, s_fstart, s_fdone;

    // 128x128 instance
    logic        b_enable, b_lcd_ready, b_mode, b_start, b_wr_en, b_ready;
    logic [6:0]  b_wx0, b_wy0, b_wx1, b_wy1, b_px, b_py;
    logic [15:0] b_wr_data, b_data;
    logic        b_valid, b_busy, b_fstart, b_fdone;

    screen_stream_controller #(.H_RES(4), .V_RES(4), .PIXEL_W(16), .ADDR_W(3)) u_small (
        .clk_main(clk_main), .rst(rst), .enable(s_enable), .lcd_ready(s_lcd_ready),
        .mode(s_mode), .start(s_start),
        .win_x0(s_wx0), .win_y0(s_wy0), .win_x1(s_wx1), .win_y1(s_wy1),
        .pixel_wr_en(s_wr_en), .pixel_addr_x(s_px), .pixel_addr_y(s_py),
        .pixel_wr_data(s_wr_data),
        .pix_out_data(s_data), .pix_out_valid(s_valid), .pix_out_ready(s_ready),
        .busy(s_busy), .frame_start(s_fstart), .frame_done(s_fdone)
    );

    screen_stream_controller u_big (
        .clk_main(clk_main), .rst(rst), .enable(b_enable), .lcd_ready(b_lcd_ready),
        .mode(b_mode), .start(b_start),
        .win_x0(b_wx0), .win_y0(b_wy0), .win_x1(b_wx1), .win_y1(b_wy1),
        .pixel_wr_en(b_wr_en), .pixel_addr_x(b_px), .pixel_addr_y(b_py),
        .pixel_wr_data(b_wr_data),
        .pix_out_data(b_data), .pix_out_valid(b_valid), .pix_out_ready(b_ready),
        .busy(b_busy), .frame_start(b_fstart), .frame_done(b_fdone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic [15:0] s_q[$];
    logic [15:0] b_q[$];
    int   cyc = 0, s_hs = 0, s_fs_cnt = 0, s_fd_cnt = 0, b_fd_cnt = 0, b_fs_cnt = 0;
    int   s_fs_cyc = 0, s_last_cyc = 0;
    bit   rate_chk = 1'b0, s_first = 1'b0, s_hold_pend = 1'b0;
    logic [15:0] s_hold_data;

    always @(negedge clk_main) begin
        cyc++;
        if (s_fstart) begin s_fs_cnt++; s_fs_cyc = cyc; s_first = 1'b1; end
        if (s_fdone) s_fd_cnt++;
        if (s_hold_pend) begin
            check("hold_valid", {31'd0, s_valid}, 32'd1);
            check("hold_data", {16'd0, s_data}, {16'd0, s_hold_data});
        end
        s_hold_pend = s_valid && !s_ready && !rst;
        s_hold_data = s_data;
        if (s_valid && s_ready) begin
            if (s_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL small_unexpected_pixel: actual=%0h expected=none", s_data);
            end else begin
                check("small_pixel", {16'd0, s_data}, {16'd0, s_q.pop_front()});
            end
            if (rate_chk) begin
                if (s_first) check("first_latency", cyc - s_fs_cyc, 32'd2);
                else         check("pixel_rate", cyc - s_last_cyc, 32'd3);
            end
            s_first = 1'b0;
            s_last_cyc = cyc;
            s_hs++;
        end
    end

    always @(negedge clk_main) begin
        if (b_fstart) b_fs_cnt++;
        if (b_fdone)  b_fd_cnt++;
        if (b_valid && b_ready) begin
            if (b_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL big_unexpected_pixel: actual=%0h expected=none", b_data);
            end else begin
                check("big_pixel", {16'd0, b_data}, {16'd0, b_q.pop_front()});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_main);
        #1;
    endtask

    task automatic s_write(input int x, input int y, input logic [15:0] d);
        s_wr_en = 1'b1; s_px = 3'(x); s_py = 3'(y); s_wr_data = d;
        tick(1);
        s_wr_en = 1'b0;
    endtask

    task automatic s_fill();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                s_write(x, y, {8'h00, 4'(y), 4'(x)});
    endtask

    task automatic s_win(input int x0, input int y0, input int x1, input int y1);
        s_wx0 = 3'(x0); s_wy0 = 3'(y0); s_wx1 = 3'(x1); s_wy1 = 3'(y1);
    endtask

    task automatic s_expect(input int x0, input int y0, input int x1, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                s_q.push_back({8'h00, 4'(y), 4'(x)});
    endtask

    task automatic s_pulse_start();
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
    endtask

    task automatic s_wait_fd(input int target, input string name);
        for (int i = 0; i < 300 && s_fd_cnt < target; i++) @(posedge clk_main);
        #1;
        check(name, s_fd_cnt, target);
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        bit restart_pend;

        rst = 1'b1;
        s_enable = 1'b1; s_lcd_ready = 1'b1; s_mode = 1'b1; s_start = 1'b0;
        s_wr_en = 1'b0; s_ready = 1'b1; s_px = '0; s_py = '0; s_wr_data = '0;
        s_win(0, 0, 3, 3);
        b_enable = 1'b1; b_lcd_ready = 1'b1; b_mode = 1'b1; b_start = 1'b0;
        b_wr_en = 1'b0; b_ready = 1'b1; b_px = '0; b_py = '0; b_wr_data = '0;
        b_wx0 = 7'd5; b_wy0 = 7'd2; b_wx1 = 7'd7; b_wy1 = 7'd3;
        tick(2);

        check("rst_valid", {31'd0, s_valid}, 32'd0);
        check("rst_data", {16'd0, s_data}, 32'd0);
        check("rst_busy", {31'd0, s_busy}, 32'd0);
        check("rst_fstart", {31'd0, s_fstart}, 32'd0);
        check("rst_fdone", {31'd0, s_fdone}, 32'd0);
        check("rst_big_valid", {31'd0, b_valid}, 32'd0);
        check("rst_big_busy", {31'd0, b_busy}, 32'd0);
        rst = 1'b0;
        tick(2);

        // 128x128 window (5,2)-(7,3) with a ring of distinct neighbours written
        for (int y = 1; y <= 4; y++)
            for (int x = 4; x <= 8; x++) begin
                b_wr_en = 1'b1; b_px = 7'(x); b_py = 7'(y);
                b_wr_data = {8'(y), 8'(x)};
                tick(1);
            end
        b_wr_en = 1'b0;
        for (int y = 2; y <= 3; y++)
            for (int x = 5; x <= 7; x++)
                b_q.push_back({8'(y), 8'(x)});
        b_start = 1'b1; tick(1); b_start = 1'b0;
        for (int i = 0; i < 100 && b_fd_cnt < 1; i++) @(posedge clk_main);
        #1;
        check("big_frame_done", b_fd_cnt, 32'd1);
        check("big_frame_start", b_fs_cnt, 32'd1);
        check("big_queue_empty", b_q.size(), 32'd0);

        // full 4x4 frame, window x1/y1 clamped from 7 to 3, plus out-of-range writes
        s_fill();
        s_write(4, 0, 16'hDEAD);
        s_write(0, 4, 16'hBEEF);
        s_win(0, 0, 7, 7);
        s_expect(0, 0, 3, 3);
        rate_chk = 1'b1;
        s_pulse_start();
        s_wait_fd(1, "full_frame_done");
        rate_chk = 1'b0;
        check("full_queue_empty", s_q.size(), 32'd0);
        check("single_busy_low", {31'd0, s_busy}, 32'd0);

        // start while enable low is dropped
        s_enable = 1'b0;
        s_pulse_start();
        s_enable = 1'b1;
        tick(10);
        check("start_dropped", s_fs_cnt, 32'd1);

        // window (1,1)-(2,2) with 10 cycles of backpressure on the first pixel
        s_win(1, 1, 2, 2);
        s_expect(1, 1, 2, 2);
        s_pulse_start();
        s_ready = 1'b0;
        for (int i = 0; i < 20 && !s_valid; i++) tick(1);
        check("bp_valid_seen", {31'd0, s_valid}, 32'd1);
        tick(10);
        s_ready = 1'b1;
        s_wait_fd(2, "bp_frame_done");
        check("bp_queue_empty", s_q.size(), 32'd0);

        // continuous mode, window changed during frame 1, mode back to single in frame 2
        s_win(2, 3, 3, 3);
        s_expect(2, 3, 3, 3);
        s_expect(0, 0, 0, 1);
        s_mode = 1'b0;
        for (int i = 0; i < 20 && !s_fstart; i++) tick(1);
        check("cont_first_start", {31'd0, s_fstart}, 32'd1);
        s_win(0, 0, 0, 1);
        n_done = 0;
        restart_pend = 1'b0;
        for (int i = 0; i < 100 && n_done < 2; i++) begin
            tick(1);
            check("cont_busy", {31'd0, s_busy}, 32'd1);
            if (restart_pend) begin
                check("cont_restart", {31'd0, s_fstart}, 32'd1);
                s_mode = 1'b1;
                restart_pend = 1'b0;
            end
            if (s_fdone) begin
                n_done++;
                if (n_done == 1) restart_pend = 1'b1;
            end
        end
        check("cont_frames", n_done, 32'd2);
        tick(10);
        check("cont_stopped", s_fs_cnt, 32'd4);
        check("cont_busy_low", {31'd0, s_busy}, 32'd0);
        check("cont_queue_empty", s_q.size(), 32'd0);

        // degenerate window substitutes the full screen
        s_win(3, 0, 1, 3);
        s_expect(0, 0, 3, 3);
        s_pulse_start();
        s_wait_fd(5, "degen_frame_done");
        check("degen_queue_empty", s_q.size(), 32'd0);

        // write collides with the read of (1,0): old value now, new value next frame
        s_win(1, 0, 1, 0);
        s_q.push_back(16'h0001);
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        s_write(1, 0, 16'hABCD);
        s_wait_fd(6, "collide_frame_done");
        s_q.push_back(16'hABCD);
        s_pulse_start();
        s_wait_fd(7, "collide_next_done");
        check("collide_queue_empty", s_q.size(), 32'd0);

        // reset while the 6th pixel is being offered
        s_fill();
        s_win(1, 0, 3, 3);
        s_expect(1, 0, 3, 3);
        begin
            int hs0;
            hs0 = s_hs;
            s_pulse_start();
            for (int i = 0; i < 100 && s_hs < hs0 + 5; i++) tick(1);
            check("rst_five_pixels", s_hs - hs0, 32'd5);
        end
        tick(2);
        check("pre_rst_valid", {31'd0, s_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, s_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, s_busy}, 32'd0);
        check("mid_rst_data", {16'd0, s_data}, 32'd0);
        s_q.delete();
        tick(1);
        rst = 1'b0;
        s_fill();
        check("no_done_on_rst", s_fd_cnt, 32'd7);
        s_expect(1, 0, 3, 3);
        s_pulse_start();
        s_wait_fd(8, "post_rst_done");
        check("post_rst_queue_empty", s_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
